// File: rtl/input_trigger_bank.sv
// ---------------------------------------------------------------------------
// input_trigger_bank
//
// This block conditions a bank of raw, bouncing trigger inputs and turns
// qualified edges into pulses.
//   1. Each input passes through a 2-flop synchroniser.
//   2. A per-channel counter accepts a new level only after it has held
//      for DB_CYCLES cycles.
//   3. Accepted edges become one-cycle pulses when the channel is enabled
//      and the edge direction matches edge_mode.
//   4. Any pulse produces a single inc_clk one cycle later.
//   5. ref_clk fires periodically, and also one cycle after inc_clk.
//      The inc-triggered refresh restarts the refresh period.
//
// Ports
//   clk        in   system clock, rising-edge
//   reset      in   synchronous active-high reset
//   trigger    in   [CHANNELS] raw asynchronous trigger inputs
//   edge_mode  in   [2] 00 rising, 01 falling, 10 both, 11 none
//   chan_en    in   [CHANNELS] per-channel pulse enable
//   level      out  [CHANNELS] debounced level of each channel
//   chan_pulse out  [CHANNELS] one-cycle pulse on a qualified debounced edge
//   inc_clk    out  one-cycle pulse, cycle after any chan_pulse
//   ref_clk    out  one-cycle refresh pulse (periodic or inc-triggered)
// ---------------------------------------------------------------------------
module input_trigger_bank #(
    parameter int CHANNELS   = 6,
    parameter int DB_CYCLES  = 10000,
    parameter int REF_PERIOD = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    input  logic [1:0]          edge_mode,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] chan_pulse,
    output logic                inc_clk,
    output logic                ref_clk
);

    // DB_CYCLES >= 2 and REF_PERIOD >= 2, so both widths are at least 1.
    // Each width holds its terminal count (N-1).
    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int REF_W = $clog2(REF_PERIOD);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_PERIOD - 1);

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [DB_W-1:0]     r_db_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_pulse;
    logic                r_inc;
    logic                r_ref_req;   // inc_clk delayed by one cycle
    logic [REF_W-1:0]    r_ref_cnt;

    logic [CHANNELS-1:0] w_accept;    // level toggles at the end of this cycle
    logic [CHANNELS-1:0] w_qual;      // accepted edge that should pulse
    logic                w_rise_ok;
    logic                w_fall_ok;
    logic                w_ref;

    assign w_rise_ok = (edge_mode == 2'b00) || (edge_mode == 2'b10);
    assign w_fall_ok = (edge_mode == 2'b01) || (edge_mode == 2'b10);

    // The edge direction follows from the synchronised input value.
    // An accepted input of 1 means level is rising.
    always_comb begin
        w_accept = '0;
        w_qual   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_accept[i] = (r_sync2[i] != r_level[i]) && (r_db_cnt[i] == DB_LAST);
            w_qual[i]   = w_accept[i] && chan_en[i] &&
                          (r_sync2[i] ? w_rise_ok : w_fall_ok);
        end
    end

    // A periodic wrap and an inc-triggered refresh can land in the same
    // cycle. They merge into one pulse and a single reload to 0.
    assign w_ref = r_ref_req || (r_ref_cnt == REF_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_pulse   <= '0;
            r_inc     <= 1'b0;
            r_ref_req <= 1'b0;
            r_ref_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= trigger;
            r_sync2 <= r_sync1;
            // A bounce back to the current level wipes all accumulated credit.
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_accept[i] || (r_sync2[i] == r_level[i])) begin
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
            r_level   <= r_level ^ w_accept;
            r_pulse   <= w_qual;
            r_inc     <= |r_pulse;
            r_ref_req <= r_inc;
            r_ref_cnt <= w_ref ? '0 : r_ref_cnt + 1'b1;
        end
    end

    assign level      = r_level;
    assign chan_pulse = r_pulse;
    assign inc_clk    = r_inc;
    assign ref_clk    = w_ref;

endmodule

// File: tb/tb_input_trigger_bank.sv
// ---------------------------------------------------------------------------
// Directed testbench for input_trigger_bank.
// Configuration: CHANNELS=6, DB_CYCLES=8, REF_PERIOD=20.
//
// Timing model used by every test
//   - Inputs are driven and outputs sampled on the falling edge.
//   - An input driven at the negedge of cycle T is captured at the edge
//     ending cycle T.
//   - The resulting level is therefore visible at the negedge of cycle T+10.
//   - chan_pulse appears at T+10, inc_clk at T+11, and the inc-triggered
//     ref_clk at T+12.
// ---------------------------------------------------------------------------
module tb_input_trigger_bank;

    localparam int CH = 6;

    logic          clk;
    logic          reset;
    logic [CH-1:0] trigger;
    logic [1:0]    edge_mode;
    logic [CH-1:0] chan_en;
    logic [CH-1:0] level;
    logic [CH-1:0] chan_pulse;
    logic          inc_clk;
    logic          ref_clk;

    int checks = 0;
    int passes = 0;

    input_trigger_bank #(
        .CHANNELS   (CH),
        .DB_CYCLES  (8),
        .REF_PERIOD (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trigger    (trigger),
        .edge_mode  (edge_mode),
        .chan_en    (chan_en),
        .level      (level),
        .chan_pulse (chan_pulse),
        .inc_clk    (inc_clk),
        .ref_clk    (ref_clk)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Reset with idle inputs.
    // Returns at the negedge where reset drops; that is post-reset cycle 1.
    task automatic apply_reset();
        reset     = 1'b1;
        trigger   = '0;
        edge_mode = 2'b00;
        chan_en   = '1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    // Outputs are zero during reset.
    // A trigger held high through release is seen as a new rise.
    task automatic test_reset();
        logic [31:0] lvl_bits;
        logic [31:0] inc_bits;
        logic [CH-1:0] pulse_at10;
        reset = 1'b1; trigger = '1; edge_mode = 2'b00; chan_en = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (level !== '0 || chan_pulse !== '0 || inc_clk !== 1'b0 || ref_clk !== 1'b0)
            $display("FAIL reset_outputs: got lvl=%b pulse=%b inc=%b ref=%b expected all 0",
                     level, chan_pulse, inc_clk, ref_clk);
        else passes++;
        reset = 1'b0;
        lvl_bits = '0; inc_bits = '0; pulse_at10 = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            lvl_bits[k] = (level == 6'h3F);
            inc_bits[k] = inc_clk;
            if (k == 10) pulse_at10 = chan_pulse;
        end
        checks++;
        if (lvl_bits !== 32'h0000_7C00)
            $display("FAIL reset_release_level: got %h expected %h", lvl_bits, 32'h0000_7C00);
        else passes++;
        checks++;
        if (pulse_at10 !== 6'h3F)
            $display("FAIL reset_release_pulse: got %b expected %b", pulse_at10, 6'h3F);
        else passes++;
        checks++;
        if (inc_bits !== 32'h0000_0800)
            $display("FAIL reset_release_inc: got %h expected %h", inc_bits, 32'h0000_0800);
        else passes++;
    endtask

    // Bounces of 4 cycles are rejected.
    // The final held rise gives exactly one pulse.
    task automatic test_debounce_bounce();
        int bounce_evts;
        logic [31:0] p_bits;
        logic [31:0] i_bits;
        logic [31:0] l_bits;
        apply_reset();
        bounce_evts = 0;
        for (int seg = 0; seg < 2; seg++) begin
            trigger[2] = (seg == 0);
            repeat (4) begin
                @(negedge clk);
                if (level[2] || chan_pulse != '0 || inc_clk) bounce_evts++;
            end
        end
        trigger[2] = 1'b1;
        p_bits = '0; i_bits = '0; l_bits = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (level[2] || chan_pulse != '0 || inc_clk) bounce_evts += (k < 8) ? 1 : 0;
            p_bits[k] = chan_pulse[2];
            i_bits[k] = inc_clk;
            l_bits[k] = level[2];
        end
        checks++;
        if (bounce_evts !== 0)
            $display("FAIL bounce_rejected: got %0d events expected 0", bounce_evts);
        else passes++;
        checks++;
        if (l_bits !== 32'h0001_FC00)
            $display("FAIL bounce_level: got %h expected %h", l_bits, 32'h0001_FC00);
        else passes++;
        checks++;
        if (p_bits !== 32'h0000_0400)
            $display("FAIL bounce_pulse: got %h expected %h", p_bits, 32'h0000_0400);
        else passes++;
        checks++;
        if (i_bits !== 32'h0000_0800)
            $display("FAIL bounce_inc: got %h expected %h", i_bits, 32'h0000_0800);
        else passes++;
    endtask

    // Two channels rise together.
    // Expect one two-bit pulse, one inc_clk, then ref_clk, then a restarted period.
    task automatic test_simultaneous();
        int pulse_cnt, pulse_k, inc_cnt, inc_k;
        logic [CH-1:0] pulse_val;
        logic [63:0] ref_bits;
        apply_reset();
        trigger = 6'b001100;
        pulse_cnt = 0; pulse_k = 0; inc_cnt = 0; inc_k = 0; pulse_val = '0; ref_bits = '0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (chan_pulse != '0) begin pulse_cnt++; pulse_k = k; pulse_val = chan_pulse; end
            if (inc_clk) begin inc_cnt++; inc_k = k; end
            ref_bits[k] = ref_clk;
        end
        checks++;
        if (pulse_cnt !== 1 || pulse_k !== 10 || pulse_val !== 6'b001100)
            $display("FAIL simul_pulse: got cnt=%0d k=%0d val=%b expected cnt=1 k=10 val=001100",
                     pulse_cnt, pulse_k, pulse_val);
        else passes++;
        checks++;
        if (inc_cnt !== 1 || inc_k !== 11)
            $display("FAIL simul_inc: got cnt=%0d k=%0d expected cnt=1 k=11", inc_cnt, inc_k);
        else passes++;
        // Inc-triggered refresh at k=12; the next periodic one lands 20 cycles later.
        checks++;
        if (ref_bits !== ((64'd1 << 12) | (64'd1 << 32)))
            $display("FAIL simul_ref: got %h expected %h", ref_bits,
                     (64'd1 << 12) | (64'd1 << 32));
        else passes++;
    endtask

    // Falling-only mode pulses only on release.
    // Both-edge mode pulses on press and on release.
    task automatic test_edge_modes();
        int press_p, press_i, rel_p, rel_i, rel_k;
        logic lvl_at10;
        apply_reset();
        edge_mode = 2'b01;
        trigger[0] = 1'b1;
        press_p = 0; press_i = 0; lvl_at10 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (chan_pulse[0]) press_p++;
            if (inc_clk) press_i++;
            if (k == 10) lvl_at10 = level[0];
        end
        trigger[0] = 1'b0;
        rel_p = 0; rel_i = 0; rel_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (chan_pulse[0]) begin rel_p++; rel_k = k; end
            if (inc_clk) rel_i++;
        end
        checks++;
        if (lvl_at10 !== 1'b1 || press_p !== 0 || press_i !== 0)
            $display("FAIL fall_mode_press: got lvl=%b pulses=%0d inc=%0d expected lvl=1 pulses=0 inc=0",
                     lvl_at10, press_p, press_i);
        else passes++;
        checks++;
        if (rel_p !== 1 || rel_k !== 10 || rel_i !== 1)
            $display("FAIL fall_mode_release: got pulses=%0d k=%0d inc=%0d expected 1 10 1",
                     rel_p, rel_k, rel_i);
        else passes++;
        edge_mode = 2'b10;
        rel_p = 0; rel_i = 0;
        for (int ph = 0; ph < 2; ph++) begin
            trigger[0] = (ph == 0);
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (chan_pulse[0]) rel_p++;
                if (inc_clk) rel_i++;
            end
        end
        checks++;
        if (rel_p !== 2 || rel_i !== 2)
            $display("FAIL both_mode: got pulses=%0d inc=%0d expected 2 2", rel_p, rel_i);
        else passes++;
    endtask

    // A disabled channel still tracks its level but never pulses.
    // Mode 11 suppresses pulses on every channel.
    task automatic test_chan_disable();
        int evts;
        apply_reset();
        chan_en = 6'b101111;
        trigger[4] = 1'b1;
        evts = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (chan_pulse != '0 || inc_clk) evts++;
        end
        checks++;
        if (level[4] !== 1'b1 || evts !== 0)
            $display("FAIL disabled_chan: got lvl=%b events=%0d expected lvl=1 events=0", level[4], evts);
        else passes++;
        chan_en = '1;
        edge_mode = 2'b11;
        trigger[5] = 1'b1;
        evts = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (chan_pulse != '0 || inc_clk) evts++;
        end
        checks++;
        if (level[5] !== 1'b1 || evts !== 0)
            $display("FAIL mode_none: got lvl=%b events=%0d expected lvl=1 events=0", level[5], evts);
        else passes++;
    endtask

    // Edges in consecutive cycles give inc_clk in consecutive cycles.
    task automatic test_back_to_back();
        logic [31:0] p0, p1, ib, rb;
        apply_reset();
        trigger[0] = 1'b1;
        @(negedge clk);
        trigger[1] = 1'b1;
        p0 = '0; p1 = '0; ib = '0; rb = '0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            p0[k] = chan_pulse[0];
            p1[k] = chan_pulse[1];
            ib[k] = inc_clk;
            rb[k] = ref_clk;
        end
        checks++;
        if (p0 !== 32'h0000_0200 || p1 !== 32'h0000_0400)
            $display("FAIL b2b_pulse: got p0=%h p1=%h expected 00000200 00000400", p0, p1);
        else passes++;
        checks++;
        if (ib !== 32'h0000_0C00)
            $display("FAIL b2b_inc: got %h expected %h", ib, 32'h0000_0C00);
        else passes++;
        checks++;
        if (rb !== 32'h0000_1800)
            $display("FAIL b2b_ref: got %h expected %h", rb, 32'h0000_1800);
        else passes++;
    endtask

    // With idle inputs, ref_clk pulses at cycles 20, 40, 60, 80 and 100.
    // No inc_clk appears.
    task automatic test_idle_refresh();
        int ref_cnt, bad_pos, inc_cnt, first_ref;
        apply_reset();
        ref_cnt = 0; bad_pos = 0; inc_cnt = 0; first_ref = 0;
        if (ref_clk) begin ref_cnt++; bad_pos++; end
        for (int cyc = 2; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (ref_clk) begin
                ref_cnt++;
                if (first_ref == 0) first_ref = cyc;
                if (cyc % 20 != 0) bad_pos++;
            end
            if (inc_clk) inc_cnt++;
        end
        checks++;
        if (ref_cnt !== 5 || bad_pos !== 0 || first_ref !== 20)
            $display("FAIL idle_ref: got cnt=%0d bad=%0d first=%0d expected 5 0 20",
                     ref_cnt, bad_pos, first_ref);
        else passes++;
        checks++;
        if (inc_cnt !== 0)
            $display("FAIL idle_inc: got %0d expected 0", inc_cnt);
        else passes++;
    endtask

    // Reset in the middle of a debounce discards the count.
    // After release the still-high input debounces afresh.
    task automatic test_reset_mid_debounce();
        int evts;
        logic [31:0] lb, pb, ib;
        apply_reset();
        trigger[1] = 1'b1;
        evts = 0;
        repeat (5) begin
            @(negedge clk);
            if (chan_pulse != '0 || inc_clk || level != '0) evts++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (chan_pulse != '0 || inc_clk || level != '0 || ref_clk) evts++;
        end
        checks++;
        if (evts !== 0)
            $display("FAIL mid_reset_quiet: got %0d events expected 0", evts);
        else passes++;
        reset = 1'b0;
        lb = '0; pb = '0; ib = '0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            lb[k] = level[1];
            pb[k] = chan_pulse[1];
            ib[k] = inc_clk;
        end
        checks++;
        if (lb !== 32'h0000_FC00)
            $display("FAIL mid_reset_level: got %h expected %h", lb, 32'h0000_FC00);
        else passes++;
        checks++;
        if (pb !== 32'h0000_0400 || ib !== 32'h0000_0800)
            $display("FAIL mid_reset_pulse: got p=%h i=%h expected 00000400 00000800", pb, ib);
        else passes++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_debounce_bounce();
        test_simultaneous();
        test_edge_modes();
        test_chan_disable();
        test_back_to_back();
        test_idle_refresh();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/input_trigger_bank.md
INPUT_TRIGGER_BANK -- requirements
Module: input_trigger_bank

Interface
REQ-001 Parameter CHANNELS, default 6: number of independent raw trigger inputs; legal range 1..32.
REQ-002 Parameter DB_CYCLES, default 10000: clock cycles a synchronised input must hold a new level before it is accepted; minimum 2.
REQ-003 Parameter REF_PERIOD, default 1000: clock cycles between periodic refresh pulses; minimum 2.
REQ-004 clk  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 trigger  input  CHANNELS  raw, asynchronous, bouncing button/sensor inputs.
REQ-007 edge_mode  input  2  qualifying edge for all channels: 00 rising, 01 falling, 10 both, 11 none.
REQ-008 chan_en  input  CHANNELS  per-channel pulse enable; 1 = edges of that channel may generate pulses.
REQ-009 level  output  CHANNELS  debounced state of each channel.
REQ-010 chan_pulse  output  CHANNELS  one-cycle pulse per channel on a qualified debounced edge.
REQ-011 inc_clk  output  1  one-cycle counter-increment pulse.
REQ-012 ref_clk  output  1  one-cycle output-refresh pulse.

Function
REQ-013 Each trigger bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 Each channel SHALL own a debounce counter wide enough for DB_CYCLES-1; counter clears in any cycle the synchronised input equals level.
REQ-015 While synchronised input differs from level, counter increments; in the cycle counter equals DB_CYCLES-1 and the input still differs, level toggles and counter clears.
REQ-016 Latency: raw input stable from cycle T updates level at the clock edge ending cycle T+2+DB_CYCLES-1 (DB_CYCLES cycles after synchroniser output changes).
REQ-017 Any bounce back to the old level before acceptance clears the counter; no partial credit is kept.
REQ-018 chan_pulse[i] SHALL assert in the same cycle level[i] changes, only if chan_en[i]=1 and the edge direction matches edge_mode; otherwise chan_pulse[i]=0.
REQ-019 Disabled channels (chan_en=0) SHALL continue debouncing and tracking level.
REQ-020 edge_mode and chan_en are sampled every cycle; a change affects the next qualified-edge evaluation, no pending edges are stored.
REQ-021 inc_clk SHALL assert exactly one cycle after any cycle with at least one chan_pulse bit set; simultaneous edges on several channels yield one inc_clk pulse.
REQ-022 Qualified edges in consecutive cycles yield inc_clk in consecutive cycles (no merging across cycles).
REQ-023 Refresh counter runs 0..REF_PERIOD-1 and wraps; ref_clk asserts for one cycle when counter equals REF_PERIOD-1.
REQ-024 ref_clk SHALL also assert in the cycle after inc_clk asserts, and that event reloads the refresh counter to 0.
REQ-025 Periodic and inc-triggered refresh in the same cycle yield a single ref_clk pulse and counter = 0 next cycle.

Reset
REQ-026 While reset=1: synchronisers, debounce counters, refresh counter, level, chan_pulse, inc_clk, ref_clk all 0.
REQ-027 Reset asserted mid-debounce discards the count; no pulse is produced for the interrupted transition.
REQ-028 A trigger held high through reset release is treated as a new rising edge: level rises DB_CYCLES+2 cycles after release and pulses as per REQ-018.
REQ-029 First periodic ref_clk after release occurs in cycle REF_PERIOD (counter 0 in first post-reset cycle).

Verification (bench params CHANNELS=6, DB_CYCLES=8, REF_PERIOD=20)
REQ-030 trigger[2] toggles every 4 cycles three times then held 1; edge_mode=00, chan_en=all 1 -> exactly one chan_pulse[2] and one inc_clk, level[2]=1 10 cycles after final rise.
REQ-031 trigger[2] and trigger[3] rise in the same cycle and stay -> chan_pulse=6'b001100 for one cycle, single inc_clk next cycle, ref_clk the cycle after, refresh counter restarts.
REQ-032 edge_mode=01, press then release trigger[0] (each held 20 cycles) -> no pulse on press, one chan_pulse[0]/inc_clk on release; edge_mode=10 repeat -> two pulses.
REQ-033 chan_en[4]=0, trigger[4] press -> level[4]=1, chan_pulse[4]=0, inc_clk=0.
REQ-034 Idle inputs 100 cycles after reset -> ref_clk pulses at cycles 20,40,60,80,100, width 1, no inc_clk.
REQ-035 Reset asserted 5 cycles into a stable trigger[1] rise, released, input still high -> no pulse before release, level[1] rises 10 cycles after release with one inc_clk.
